// File: rtl/keypad_pkg.sv
// Purpose: shared FSM state type, key code width and key-to-function constants for the keypad.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN         = 2'd0,
        DEBOUNCE     = 2'd1,
        PRESSED      = 2'd2,
        DEBOUNCE_REL = 2'd3
    } kp_state_t;

    localparam int KEY_CODE_W = 4;

    // Function keys, encoded as {row_idx, col_idx}
    localparam logic [KEY_CODE_W-1:0] KEY_ENTER = 4'hF;
    localparam logic [KEY_CODE_W-1:0] KEY_CLEAR = 4'hC;

    // Digit keys: the code value equals the digit
    localparam logic [KEY_CODE_W-1:0] KEY_DIGIT_0 = 4'h0;
    localparam logic [KEY_CODE_W-1:0] KEY_DIGIT_1 = 4'h1;
    localparam logic [KEY_CODE_W-1:0] KEY_DIGIT_2 = 4'h2;
    localparam logic [KEY_CODE_W-1:0] KEY_DIGIT_3 = 4'h3;
    localparam logic [KEY_CODE_W-1:0] KEY_DIGIT_4 = 4'h4;
    localparam logic [KEY_CODE_W-1:0] KEY_DIGIT_5 = 4'h5;
    localparam logic [KEY_CODE_W-1:0] KEY_DIGIT_6 = 4'h6;
    localparam logic [KEY_CODE_W-1:0] KEY_DIGIT_7 = 4'h7;
    localparam logic [KEY_CODE_W-1:0] KEY_DIGIT_8 = 4'h8;
    localparam logic [KEY_CODE_W-1:0] KEY_DIGIT_9 = 4'h9;

    // Pack a row/column position into the key code
    function automatic logic [KEY_CODE_W-1:0] make_key_code(input logic [1:0] row,
                                                           input logic [1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/keypad_scanner_scan_tick_gen.sv
// Purpose: free-running divider producing a one-cycle tick every SCAN_DIV clocks (row dwell / digit mux).
// Latency: tick is high during the cycle the counter sits at SCAN_DIV-1; first tick SCAN_DIV-1 cycles after reset.
// Backpressure: none; the tick never stalls.
module scan_tick_gen #(
    parameter int SCAN_DIV = 8192
) (
    input  logic clkt,
    input  logic rst_nt,
    output logic tick
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    assign tick = (div_cnt == DIV_LAST);

    // Count 0..SCAN_DIV-1 and wrap on the tick cycle
    always_ff @(posedge clkt or negedge rst_nt) begin
        if (!rst_nt) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Purpose: 4x4 matrix keypad scanner; strobes rows, debounces columns, emits one event per physical press.
// Latency: stable press to key_valid within (NROWS+DEBOUNCE_SCANS)*SCAN_DIV+3 clocks.
// Backpressure: none; key_valid is a one-cycle pulse and key_code holds until the next event.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 8192,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int NROWS          = 4,
    parameter int NCOLS          = 4
) (
    input  logic                  clkt,
    input  logic                  rst_nt,
    input  logic [NCOLS-1:0]      col_in,
    output logic [NROWS-1:0]      row_out,
    output logic                  key_valid,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_held,
    output logic                  multi_key
);

    localparam int ROW_W = $clog2(NROWS);
    localparam int COL_W = $clog2(NCOLS);
    localparam int NLOW_W = $clog2(NCOLS + 1);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NROWS - 1);

    logic                  tick;
    logic [NCOLS-1:0]      col_m;
    logic [NCOLS-1:0]      col_s;

    kp_state_t             state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [ROW_W-1:0]      row_idx, row_nxt, row_adv;
    logic [NCOLS-1:0]      col_pat, col_pat_nxt;
    logic [COL_W-1:0]      col_idx, col_idx_nxt;
    logic [KEY_CODE_W-1:0] key_code_nxt;
    logic                  key_held_nxt;
    logic                  multi_key_nxt;
    logic                  key_valid_nxt;

    logic [NLOW_W-1:0]     n_low;
    logic [COL_W-1:0]      col_idx_s;
    logic                  all_high;
    logic                  one_low;
    logic                  many_low;

    scan_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick (
        .clkt   (clkt),
        .rst_nt (rst_nt),
        .tick   (tick)
    );

    // Two-flop synchronizer; idle (pulled-up) lines reset to all-ones
    always_ff @(posedge clkt or negedge rst_nt) begin
        if (!rst_nt) begin
            col_m <= '1;
            col_s <= '1;
        end else begin
            col_m <= col_in;
            col_s <= col_m;
        end
    end

    // Classify the synchronized column pattern: how many lines are low and which one
    always_comb begin
        n_low     = '0;
        col_idx_s = '0;
        for (int c = 0; c < NCOLS; c++) begin
            if (!col_s[c]) begin
                n_low     = n_low + 1'b1;
                col_idx_s = COL_W'(c);
            end
        end
        all_high = (n_low == '0);
        one_low  = (n_low == NLOW_W'(1));
        many_low = !all_high && !one_low;
    end

    // Active-low one-hot row drive decoded from the current row index
    always_comb begin
        row_out          = '1;
        row_out[row_idx] = 1'b0;
        row_adv          = (row_idx == ROW_LAST) ? '0 : row_idx + 1'b1;
    end

    // FSM next state, debounce counter and output updates; everything moves on tick only
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        row_nxt       = row_idx;
        col_pat_nxt   = col_pat;
        col_idx_nxt   = col_idx;
        key_code_nxt  = key_code;
        key_held_nxt  = key_held;
        multi_key_nxt = multi_key;
        key_valid_nxt = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (all_high) begin
                        row_nxt = row_adv;
                    end else if (one_low) begin
                        col_pat_nxt = col_s;
                        col_idx_nxt = col_idx_s;
                        cnt_nxt     = CNT_W'(1);
                        state_nxt   = DEBOUNCE;
                    end else begin
                        // Ambiguous press: park on this row until everything is released
                        multi_key_nxt = 1'b1;
                        cnt_nxt       = '0;
                        state_nxt     = DEBOUNCE_REL;
                    end
                end
                DEBOUNCE: begin
                    if (col_s == col_pat) begin
                        if (cnt == CNT_LAST) begin
                            cnt_nxt       = '0;
                            key_code_nxt  = make_key_code(2'(row_idx), 2'(col_idx));
                            key_valid_nxt = 1'b1;
                            key_held_nxt  = 1'b1;
                            state_nxt     = PRESSED;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end else begin
                        cnt_nxt   = '0;
                        row_nxt   = row_adv;
                        state_nxt = SCAN;
                    end
                end
                PRESSED: begin
                    if (all_high) begin
                        cnt_nxt   = CNT_W'(1);
                        state_nxt = DEBOUNCE_REL;
                    end else if (many_low) begin
                        multi_key_nxt = 1'b1;
                    end
                end
                DEBOUNCE_REL: begin
                    if (all_high) begin
                        if (cnt == CNT_LAST) begin
                            cnt_nxt       = '0;
                            key_held_nxt  = 1'b0;
                            multi_key_nxt = 1'b0;
                            row_nxt       = row_adv;
                            state_nxt     = SCAN;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end else begin
                        cnt_nxt = '0;
                    end
                end
                default: begin
                    cnt_nxt   = '0;
                    state_nxt = SCAN;
                end
            endcase
        end
    end

    // State and output registers; reset discards any press in flight
    always_ff @(posedge clkt or negedge rst_nt) begin
        if (!rst_nt) begin
            state     <= SCAN;
            cnt       <= '0;
            row_idx   <= '0;
            col_pat   <= '1;
            col_idx   <= '0;
            key_code  <= '0;
            key_held  <= 1'b0;
            multi_key <= 1'b0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            row_idx   <= row_nxt;
            col_pat   <= col_pat_nxt;
            col_idx   <= col_idx_nxt;
            key_code  <= key_code_nxt;
            key_held  <= key_held_nxt;
            multi_key <= multi_key_nxt;
            key_valid <= key_valid_nxt;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Purpose: directed self-checking bench for keypad_scanner with a behavioural 4x4 key matrix.
// Latency: n/a.
// Backpressure: n/a.
module tb_keypad_scanner;

    logic       clkt = 1'b0;
    logic       rst_nt = 1'b0;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;
    logic       multi_key;

    // keys[row*4+col] = 1 means that key is physically pressed
    logic [15:0] keys = 16'h0000;

    int checks = 0;
    int errors = 0;
    int vld_cnt = 0;
    logic [3:0] last_code = 4'h0;

    keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (4),
        .NROWS          (4),
        .NCOLS          (4)
    ) dut (
        .clkt      (clkt),
        .rst_nt    (rst_nt),
        .col_in    (col_in),
        .row_out   (row_out),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_held  (key_held),
        .multi_key (multi_key)
    );

    always #5 clkt = ~clkt;

    // Key matrix: a pressed key pulls its column low while its row is driven low
    always_comb begin
        col_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row_out[r] && keys[r*4+c]) col_in[c] = 1'b0;
            end
        end
    end

    // Event monitor: counts key_valid cycles and remembers the code seen with them
    always @(negedge clkt) begin
        if (key_valid) begin
            vld_cnt   = vld_cnt + 1;
            last_code = key_code;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clkt);
        #1;
    endtask

    task automatic test_reset;
        logic [3:0] rows [4];
        logic [3:0] exp_row;
        rows = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        rst_nt = 1'b0;
        step(3);
        checks++; if (row_out !== 4'b1110) begin errors++; $display("FAIL rst_row_out: got %b expected %b", row_out, 4'b1110); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rst_key_valid: got %b expected 0", key_valid); end
        checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL rst_key_code: got %h expected 0", key_code); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL rst_key_held: got %b expected 0", key_held); end
        checks++; if (multi_key !== 1'b0) begin errors++; $display("FAIL rst_multi_key: got %b expected 0", multi_key); end
        @(negedge clkt);
        rst_nt = 1'b1;
        for (int i = 1; i < 20; i++) begin
            @(negedge clkt);
            exp_row = rows[(i / 4) % 4];
            checks++;
            if (row_out !== exp_row) begin
                errors++;
                $display("FAIL row_step[%0d]: got %b expected %b", i, row_out, exp_row);
            end
        end
        #1;
        checks++; if (vld_cnt !== 0) begin errors++; $display("FAIL idle_no_event: got %0d events expected 0", vld_cnt); end
    endtask

    task automatic test_clean_press;
        int base;
        int lat;
        int rel_n;
        base = vld_cnt;
        lat = 0;
        keys = 16'h0000;
        keys[9] = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clkt);
            if (key_valid) begin lat = n; break; end
        end
        checks++; if (lat == 0 || lat > 35) begin errors++; $display("FAIL press_latency: got %0d cycles expected 1..35", lat); end
        checks++; if (key_code !== 4'h9) begin errors++; $display("FAIL press_code_at_valid: got %h expected 9", key_code); end
        #1;
        step(200 - lat);
        checks++; if (vld_cnt - base !== 1) begin errors++; $display("FAIL press_one_event: got %0d events expected 1", vld_cnt - base); end
        checks++; if (last_code !== 4'h9) begin errors++; $display("FAIL press_event_code: got %h expected 9", last_code); end
        checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL press_held: got %b expected 1", key_held); end
        checks++; if (multi_key !== 1'b0) begin errors++; $display("FAIL press_multi: got %b expected 0", multi_key); end
        keys = 16'h0000;
        rel_n = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clkt);
            if (!key_held) begin rel_n = n; break; end
        end
        checks++; if (rel_n < 15 || rel_n > 18) begin errors++; $display("FAIL release_debounce: got %0d cycles expected 15..18", rel_n); end
        #1;
        checks++; if (vld_cnt - base !== 1) begin errors++; $display("FAIL release_no_event: got %0d events expected 1", vld_cnt - base); end
    endtask

    task automatic test_bounce;
        int base;
        int found;
        base = vld_cnt;
        for (int i = 0; i < 6; i++) begin
            keys[7] = ((i % 2) == 0);
            step(5);
        end
        checks++; if (vld_cnt - base !== 0) begin errors++; $display("FAIL bounce_rejected: got %0d events expected 0", vld_cnt - base); end
        keys[7] = 1'b1;
        found = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clkt);
            if (key_valid) begin found = 1; break; end
        end
        checks++; if (found == 0 || key_code !== 4'h7) begin errors++; $display("FAIL bounce_stable_event: found %0d code %h expected found 1 code 7", found, key_code); end
        #1;
        step(60);
        checks++; if (vld_cnt - base !== 1) begin errors++; $display("FAIL bounce_single_event: got %0d events expected 1", vld_cnt - base); end
        keys = 16'h0000;
        found = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clkt);
            if (!key_held) begin found = 1; break; end
        end
        checks++; if (found == 0) begin errors++; $display("FAIL bounce_release: key_held still %b expected 0", key_held); end
        #1;
    endtask

    task automatic test_multi;
        int base;
        base = vld_cnt;
        keys = 16'h0005;
        step(60);
        checks++; if (multi_key !== 1'b1) begin errors++; $display("FAIL multi_set: got %b expected 1", multi_key); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL multi_no_held: got %b expected 0", key_held); end
        checks++; if (vld_cnt - base !== 0) begin errors++; $display("FAIL multi_no_event: got %0d events expected 0", vld_cnt - base); end
        keys = 16'h0000;
        step(8);
        checks++; if (multi_key !== 1'b1) begin errors++; $display("FAIL multi_hold_during_rel: got %b expected 1", multi_key); end
        step(30);
        checks++; if (multi_key !== 1'b0) begin errors++; $display("FAIL multi_clear: got %b expected 0", multi_key); end
    endtask

    task automatic test_reset_mid_press;
        int base;
        int found;
        base = vld_cnt;
        keys = 16'h0000;
        keys[12] = 1'b1;
        found = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clkt);
            if (row_out === 4'b0111) begin found = 1; break; end
        end
        checks++; if (found == 0) begin errors++; $display("FAIL midrst_reach_row3: row_out %b expected 0111", row_out); end
        step(6);
        checks++; if (row_out !== 4'b0111 || key_held !== 1'b0) begin errors++; $display("FAIL midrst_debouncing: row %b held %b expected 0111 0", row_out, key_held); end
        rst_nt = 1'b0;
        @(negedge clkt);
        checks++; if (row_out !== 4'b1110) begin errors++; $display("FAIL midrst_row_out: got %b expected 1110", row_out); end
        checks++; if (key_valid !== 1'b0 || key_held !== 1'b0 || multi_key !== 1'b0) begin errors++; $display("FAIL midrst_flags: valid %b held %b multi %b expected 0 0 0", key_valid, key_held, multi_key); end
        checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL midrst_key_code: got %h expected 0", key_code); end
        keys = 16'h0000;
        step(2);
        rst_nt = 1'b1;
        step(60);
        checks++; if (vld_cnt - base !== 0) begin errors++; $display("FAIL midrst_no_event: got %0d events expected 0", vld_cnt - base); end
    endtask

    task automatic test_two_rows;
        int base;
        int found;
        base = vld_cnt;
        keys = 16'h0000;
        keys[0] = 1'b1;
        found = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clkt);
            if (key_valid) begin found = 1; break; end
        end
        checks++; if (found == 0 || key_code !== 4'h0) begin errors++; $display("FAIL tworow_first: found %0d code %h expected found 1 code 0", found, key_code); end
        #1;
        keys[10] = 1'b1;
        step(60);
        checks++; if (vld_cnt - base !== 1) begin errors++; $display("FAIL tworow_blocked: got %0d events expected 1", vld_cnt - base); end
        checks++; if (row_out !== 4'b1110 || key_held !== 1'b1) begin errors++; $display("FAIL tworow_frozen: row %b held %b expected 1110 1", row_out, key_held); end
        keys[0] = 1'b0;
        found = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clkt);
            if (key_valid) begin found = 1; break; end
        end
        checks++; if (found == 0 || key_code !== 4'hA) begin errors++; $display("FAIL tworow_second: found %0d code %h expected found 1 code a", found, key_code); end
        #1;
        checks++; if (vld_cnt - base !== 2) begin errors++; $display("FAIL tworow_total: got %0d events expected 2", vld_cnt - base); end
        keys = 16'h0000;
        step(40);
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL tworow_release: got %b expected 0", key_held); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_multi();
        test_reset_mid_press();
        test_two_rows();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
